// File: rtl/test_card_bounce.sv
// test_card_bounce: bouncing-square test card on a display timing stream, 2-cycle registered RGB/sync/de.
module test_card_bounce #(
    parameter int          H_RES     = 640,
    parameter int          V_RES     = 480,
    parameter int          SQ_SIZE   = 32,
    parameter int          SPEED     = 1,
    parameter logic [23:0] BG_COLOUR = 24'h000040,
    parameter logic        H_POL     = 1'b0,
    parameter logic        V_POL     = 1'b0
) (
    input  logic               i_pix_clk,
    input  logic               i_rst_n,
    input  logic signed [15:0] i_sx,
    input  logic signed [15:0] i_sy,
    input  logic               i_de,
    input  logic               i_hs,
    input  logic               i_vs,
    input  logic               i_frame,
    input  logic               i_pause,
    output logic [7:0]         o_red,
    output logic [7:0]         o_green,
    output logic [7:0]         o_blue,
    output logic               o_hs,
    output logic               o_vs,
    output logic               o_de
);
    localparam logic [15:0] X_MAX = 16'(H_RES - SQ_SIZE);
    localparam logic [15:0] Y_MAX = 16'(V_RES - SQ_SIZE);
    localparam logic [15:0] STEP  = 16'(SPEED);
    localparam logic [16:0] SQ    = 17'(SQ_SIZE);
    logic [15:0] qx, qy, qx_n, qy_n;
    logic        dx_neg, dy_neg, bx, by, hit;
    logic [1:0]  cidx;
    logic [23:0] pal;
    logic        hit1, de1, hs1, vs1;
    // dx_neg/dy_neg = moving left/up; bx/by flag a clamp (bounce) on this update
    always_comb begin
        bx   = dx_neg ? (qx <= STEP) : (qx + STEP >= X_MAX);
        by   = dy_neg ? (qy <= STEP) : (qy + STEP >= Y_MAX);
        qx_n = dx_neg ? (bx ? 16'd0 : qx - STEP) : (bx ? X_MAX : qx + STEP);
        qy_n = dy_neg ? (by ? 16'd0 : qy - STEP) : (by ? Y_MAX : qy + STEP);
        hit  = !i_sx[15] && !i_sy[15]
            && $unsigned(i_sx) >= qx && {1'b0, $unsigned(i_sx)} < {1'b0, qx} + SQ
            && $unsigned(i_sy) >= qy && {1'b0, $unsigned(i_sy)} < {1'b0, qy} + SQ;
        pal  = cidx == 2'd0 ? 24'hFFFFFF : cidx == 2'd1 ? 24'hFF0000 :
               cidx == 2'd2 ? 24'h00FF00 : 24'hFFFF00;
    end
    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            qx     <= '0;
            qy     <= '0;
            dx_neg <= 1'b0;
            dy_neg <= 1'b0;
            cidx   <= '0;
            hit1   <= 1'b0;
            de1    <= 1'b0;
            hs1    <= ~H_POL;
            vs1    <= ~V_POL;
            {o_red, o_green, o_blue} <= '0;
            o_de   <= 1'b0;
            o_hs   <= ~H_POL;
            o_vs   <= ~V_POL;
        end else begin
            if (i_frame && !i_pause) begin
                qx     <= qx_n;
                qy     <= qy_n;
                dx_neg <= dx_neg ^ bx;
                dy_neg <= dy_neg ^ by;
                cidx   <= cidx + 2'(bx || by);
            end
            hit1 <= hit;
            de1  <= i_de;
            hs1  <= i_hs;
            vs1  <= i_vs;
            {o_red, o_green, o_blue} <= !de1 ? 24'h0 : hit1 ? pal : BG_COLOUR;
            o_de <= de1;
            o_hs <= hs1;
            o_vs <= vs1;
        end
    end
endmodule

// File: tb/tb_test_card_bounce.sv
// tb_test_card_bounce: random timing stream against a frame-level square/palette model, two DUT geometries.
module tb_test_card_bounce;
    localparam int SQ  = 32;
    localparam int SPD = 1;
    localparam logic [23:0] BG = 24'h000040;
    localparam int HRES [2] = '{640, 480};
    localparam int VRES = 480;
    localparam logic [23:0] PAL [4] = '{24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'hFFFF00};
    logic clk = 1'b0, clk_run = 1'b0, rst_n = 1'b1;
    logic signed [15:0] sx = '0, sy = '0;
    logic de = 1'b0, hs = 1'b1, vs = 1'b1, frame = 1'b0, pause = 1'b0;
    logic [7:0] r0, g0, b0, r1, g1, b1;
    logic hs0, vs0, de0, hs1, vs1, de1;
    int vectors = 0, miscompares = 0;
    int mqx [2], mqy [2], mc [2];
    bit mdxn [2], mdyn [2], mhit [2];
    bit mde, mhs, mvs, ede, ehs, evs;
    logic [23:0] erg [2];
    always #5 if (clk_run) clk = ~clk;
    test_card_bounce dut0 (
        .i_pix_clk(clk), .i_rst_n(rst_n), .i_sx(sx), .i_sy(sy), .i_de(de), .i_hs(hs), .i_vs(vs),
        .i_frame(frame), .i_pause(pause), .o_red(r0), .o_green(g0), .o_blue(b0),
        .o_hs(hs0), .o_vs(vs0), .o_de(de0));
    test_card_bounce #(.H_RES(480)) dut1 (
        .i_pix_clk(clk), .i_rst_n(rst_n), .i_sx(sx), .i_sy(sy), .i_de(de), .i_hs(hs), .i_vs(vs),
        .i_frame(frame), .i_pause(pause), .o_red(r1), .o_green(g1), .o_blue(b1),
        .o_hs(hs1), .o_vs(vs1), .o_de(de1));
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
        end
    endtask
    function automatic bit bnc(int q, bit neg, int lim);
        return neg ? q <= SPD : q + SPD >= lim - SQ;
    endfunction
    function automatic int nxt(int q, bit neg, int lim);
        if (bnc(q, neg, lim)) return neg ? 0 : lim - SQ;
        return neg ? q - SPD : q + SPD;
    endfunction
    function automatic bit inside_sq(int x, int y, int qx, int qy);
        return x >= 0 && y >= 0 && x >= qx && x < qx + SQ && y >= qy && y < qy + SQ;
    endfunction
    // Reference: square moves by whole frames; colour chosen one cycle after the hit test
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mqx[i] <= 0; mqy[i] <= 0; mdxn[i] <= 0; mdyn[i] <= 0; mc[i] <= 0;
                mhit[i] <= 0; erg[i] <= '0;
            end
            mde <= 0; mhs <= 1; mvs <= 1; ede <= 0; ehs <= 1; evs <= 1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                erg[i]  <= !mde ? 24'h0 : mhit[i] ? PAL[mc[i]] : BG;
                mhit[i] <= inside_sq(int'(sx), int'(sy), mqx[i], mqy[i]);
                if (frame && !pause) begin
                    mqx[i]  <= nxt(mqx[i], mdxn[i], HRES[i]);
                    mqy[i]  <= nxt(mqy[i], mdyn[i], VRES);
                    mdxn[i] <= mdxn[i] ^ bnc(mqx[i], mdxn[i], HRES[i]);
                    mdyn[i] <= mdyn[i] ^ bnc(mqy[i], mdyn[i], VRES);
                    mc[i]   <= (mc[i] + int'(bnc(mqx[i], mdxn[i], HRES[i]) || bnc(mqy[i], mdyn[i], VRES))) % 4;
                end
            end
            ede <= mde; ehs <= mhs; evs <= mvs;
            mde <= de; mhs <= hs; mvs <= vs;
        end
    end
    always @(negedge clk) if (rst_n) begin
        chk("rgb0", {8'h0, r0, g0, b0}, {8'h0, erg[0]});
        chk("rgb1", {8'h0, r1, g1, b1}, {8'h0, erg[1]});
        chk("sync0", {29'h0, de0, hs0, vs0}, {29'h0, ede, ehs, evs});
        chk("sync1", {29'h0, de1, hs1, vs1}, {29'h0, ede, ehs, evs});
    end
    task automatic pulse(input int n);
        repeat (n) begin
            @(negedge clk); frame = 1; de = 0;
            @(negedge clk); frame = 0;
        end
    endtask
    task automatic check_pix(input int x, input int y, input logic d, input logic [23:0] w0, input logic [23:0] w1);
        @(negedge clk); sx = 16'(x); sy = 16'(y); de = d;
        @(negedge clk); de = 0;
        @(negedge clk);
        chk("pix0", {8'h0, r0, g0, b0}, {8'h0, w0});
        chk("pix1", {8'h0, r1, g1, b1}, {8'h0, w1});
    endtask
    initial begin
        #2 rst_n = 0;
        #1;
        chk("rst_rgb", {8'h0, r0, g0, b0}, 32'h0);
        chk("rst_sync", {29'h0, de0, hs0, vs0}, 32'h3);
        chk("rst_sync1", {29'h0, de1, hs1, vs1}, 32'h3);
        clk_run = 1;
        repeat (3) @(negedge clk);
        rst_n = 1;
        for (int s = 0; s <= 42; s++) begin
            @(negedge clk);
            if (s >= 2) begin
                chk("row0", {8'h0, r0, g0, b0}, (s - 2 < 32) ? 32'hFFFFFF : 32'h000040);
                chk("row1", {8'h0, r1, g1, b1}, (s - 2 < 32) ? 32'hFFFFFF : 32'h000040);
            end
            sx = 16'(s); sy = 0; de = s <= 40;
        end
        de = 0;
        pulse(448);
        check_pix(448, 448, 1, 24'hFF0000, 24'hFF0000);
        check_pix(479, 479, 1, 24'hFF0000, 24'hFF0000);
        check_pix(447, 448, 1, BG, BG);
        pulse(160);
        check_pix(608, 288, 1, 24'h00FF00, BG);
        check_pix(607, 288, 1, BG, BG);
        check_pix(288, 288, 1, BG, 24'hFF0000);
        pulse(1);
        check_pix(607, 287, 1, 24'h00FF00, BG);
        check_pix(639, 287, 1, BG, BG);
        check_pix(287, 287, 1, BG, 24'hFF0000);
        pause = 1;
        pulse(10);
        pause = 0;
        check_pix(607, 287, 1, 24'h00FF00, BG);
        check_pix(287, 287, 1, BG, 24'hFF0000);
        check_pix(286, 287, 1, BG, BG);
        check_pix(607, 287, 0, 24'h0, 24'h0);
        check_pix(-1, 287, 1, BG, BG);
        @(negedge clk); hs = 0; vs = 0;
        @(negedge clk); chk("hs_lat1", {30'h0, hs0, vs0}, 32'h3);
        @(negedge clk); chk("hs_lat2", {30'h0, hs0, vs0}, 32'h0);
        hs = 1; vs = 1;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (c == 3000) rst_n = 0;
            if (c == 3002) rst_n = 1;
            frame = ($urandom % 8) == 0;
            de = frame ? 1'b0 : ($urandom % 4) != 0;
            if ($urandom % 16 == 0) pause = ~pause;
            if ($urandom % 8 == 0) hs = ~hs;
            if ($urandom % 8 == 0) vs = ~vs;
            if ($urandom % 2 == 0) begin
                int k = $urandom % 2;
                sx = 16'(mqx[k] - 3 + int'($urandom % 38));
                sy = 16'(mqy[k] - 3 + int'($urandom % 38));
            end else begin
                sx = 16'(int'($urandom_range(0, 720)) - 20);
                sy = 16'(int'($urandom_range(0, 520)) - 20);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
